// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg: shared types for the RSA exponentiation sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rsa_pkg;

  localparam int RSA_WIDTH = 8;
  localparam logic [RSA_WIDTH-1:0] ONE = RSA_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE_M  = 3'd1,
    PRE_X  = 3'd2,
    SQUARE = 3'd3,
    MULT   = 3'd4,
    NEXT   = 3'd5,
    POST   = 3'd6,
    DONE   = 3'd7
  } rsa_state_e;

  typedef enum logic [1:0] {
    ISS_IDLE  = 2'd0,
    ISS_ISSUE = 2'd1,
    ISS_WAIT  = 2'd2
  } iss_state_e;

  typedef enum logic [2:0] {
    SEL_M     = 3'd0,
    SEL_ONE   = 3'd1,
    SEL_CONST = 3'd2,
    SEL_XBAR  = 3'd3,
    SEL_MBAR  = 3'd4
  } opsel_e;

  typedef struct packed {
    opsel_e a;
    opsel_e b;
  } opsel_t;

  // Operand pair fed to the MMM in each op state.
  function automatic opsel_t op_sel(input rsa_state_e s);
    opsel_t r;
    r.a = SEL_ONE;
    r.b = SEL_ONE;
    case (s)
      PRE_M:   begin r.a = SEL_M;    r.b = SEL_CONST; end
      PRE_X:   begin r.a = SEL_ONE;  r.b = SEL_CONST; end
      SQUARE:  begin r.a = SEL_XBAR; r.b = SEL_XBAR;  end
      MULT:    begin r.a = SEL_XBAR; r.b = SEL_MBAR;  end
      POST:    begin r.a = SEL_XBAR; r.b = SEL_ONE;   end
      default: begin r.a = SEL_ONE;  r.b = SEL_ONE;   end
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rsa_op_issue.sv
// ---------------------------------------------------------------------------
// rsa_op_issue: one-op MMM issue/wait handshake with abort.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rsa_op_issue
  import rsa_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic launch,
  input  logic abort,
  input  logic mmm_done,
  output logic mmm_start,
  output logic mmm_abort,
  output logic op_done
);

  iss_state_e state, state_n;
  logic       abort_q;

  // A launch arriving with the completing done chains straight into the next issue.
  always_comb begin
    state_n = state;
    case (state)
      ISS_IDLE:  if (launch) state_n = ISS_ISSUE;
      ISS_ISSUE: state_n = ISS_WAIT;
      ISS_WAIT:  if (mmm_done) state_n = launch ? ISS_ISSUE : ISS_IDLE;
      default:   state_n = ISS_IDLE;
    endcase
    if (abort) state_n = ISS_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ISS_IDLE;
      abort_q <= 1'b0;
    end else if (ena) begin
      state   <= state_n;
      abort_q <= abort && (state != ISS_IDLE);
    end
  end

  assign mmm_start = (state == ISS_ISSUE);
  assign mmm_abort = abort_q;
  assign op_done   = (state == ISS_WAIT) && mmm_done;

endmodule

`default_nettype wire

// File: rtl/rsa_exp_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_exp_ctrl: left-to-right square-and-multiply sequencer over an MMM.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] rsa_p,
  input  logic [WIDTH-1:0] rsa_e,
  input  logic [WIDTH-1:0] rsa_m,
  input  logic [WIDTH-1:0] rsa_const,
  output logic             mmm_start,
  output logic [WIDTH-1:0] mmm_a,
  output logic [WIDTH-1:0] mmm_b,
  output logic [WIDTH-1:0] mmm_p,
  output logic             mmm_abort,
  input  logic             mmm_done,
  input  logic [WIDTH-1:0] mmm_result,
  output logic [WIDTH-1:0] rsa_c,
  output logic             eoc,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rsa_state_e       state, state_n;
  logic [WIDTH-1:0] p_q, e_q, m_q, k_q, m_bar, x_bar;
  logic [IW-1:0]    bit_idx;
  logic             accept, halt, launch, op_done, is_op;
  opsel_t           sel;

  assign busy   = !((state == IDLE) || (state == DONE));
  assign is_op  = (state == PRE_M) || (state == PRE_X) || (state == SQUARE) ||
                  (state == MULT) || (state == POST);
  assign accept = start && !stop && !busy;
  assign halt   = stop && busy;
  assign mmm_p  = p_q;

  function automatic logic [WIDTH-1:0] operand(input opsel_e s);
    case (s)
      SEL_M:     return m_q;
      SEL_ONE:   return WIDTH'(ONE);
      SEL_CONST: return k_q;
      SEL_XBAR:  return x_bar;
      SEL_MBAR:  return m_bar;
      default:   return '0;
    endcase
  endfunction

  always_comb begin
    sel   = op_sel(state);
    mmm_a = '0;
    mmm_b = '0;
    if (is_op) begin
      mmm_a = operand(sel.a);
      mmm_b = operand(sel.b);
    end
  end

  // launch is raised on the edge that enters an op state so its issue cycle is the first one.
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    case (state)
      IDLE, DONE: if (accept) begin state_n = PRE_M; launch = 1'b1; end
      PRE_M:      if (op_done) begin state_n = PRE_X; launch = 1'b1; end
      PRE_X:      if (op_done) begin state_n = SQUARE; launch = 1'b1; end
      SQUARE: begin
        if (op_done) begin
          if (e_q[bit_idx]) begin
            state_n = MULT;
            launch  = 1'b1;
          end else begin
            state_n = NEXT;
          end
        end
      end
      MULT:       if (op_done) state_n = NEXT;
      NEXT: begin
        launch  = 1'b1;
        state_n = (bit_idx == '0) ? POST : SQUARE;
      end
      POST:       if (op_done) state_n = DONE;
      default:    state_n = IDLE;
    endcase
    if (halt) begin
      state_n = IDLE;
      launch  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      p_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      m_bar   <= '0;
      x_bar   <= '0;
      bit_idx <= '0;
      rsa_c   <= '0;
      eoc     <= 1'b0;
    end else if (ena) begin
      state <= state_n;
      if (accept) begin
        p_q     <= rsa_p;
        e_q     <= rsa_e;
        m_q     <= rsa_m;
        k_q     <= rsa_const;
        bit_idx <= IW'(WIDTH - 1);
        eoc     <= 1'b0;
      end else if (stop) begin
        eoc <= 1'b0;
      end
      if (op_done && !halt) begin
        case (state)
          PRE_M:               m_bar <= mmm_result;
          PRE_X, SQUARE, MULT: x_bar <= mmm_result;
          POST: begin
            rsa_c <= mmm_result;
            eoc   <= 1'b1;
          end
          default: ;
        endcase
      end
      if ((state == NEXT) && !halt && (bit_idx != '0))
        bit_idx <= bit_idx - IW'(1);
    end
  end

  rsa_op_issue u_issue (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .launch    (launch),
    .abort     (halt),
    .mmm_done  (mmm_done),
    .mmm_start (mmm_start),
    .mmm_abort (mmm_abort),
    .op_done   (op_done)
  );

endmodule

`default_nettype wire

// File: doc/rsa_exp_ctrl.md
Name: rsa_exp_ctrl

Overview:
Sequencer for RSA modular exponentiation c = m^e mod p using left-to-right square-and-multiply over an external Montgomery multiplier (MMM).
- Sits between the SPI register bank and the MMM.
- Takes start/stop command pulses and operands p, e, m, const (const = R^2 mod p, R = 2^WIDTH).
- Schedules every MMM operation.
- Returns rsa_c with eoc, which the register bank samples into the result register and status bit 0.

Parameters:
WIDTH, 8, operand/modulus width; also the exponent bit count.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ena  in  1  clock enable; when low all state holds
start  in  1  one-cycle start command pulse
stop  in  1  one-cycle abort command pulse
rsa_p  in  WIDTH  modulus, odd
rsa_e  in  WIDTH  exponent
rsa_m  in  WIDTH  message, must be < p
rsa_const  in  WIDTH  R^2 mod p
mmm_start  out  1  one-cycle pulse launching an MMM op
mmm_a  out  WIDTH  MMM operand A, stable from the pulse until mmm_done
mmm_b  out  WIDTH  MMM operand B, stable from the pulse until mmm_done
mmm_p  out  WIDTH  latched modulus
mmm_abort  out  1  one-cycle pulse cancelling an in-flight MMM op
mmm_done  in  1  one-cycle pulse; mmm_result is valid in the same cycle
mmm_result  in  WIDTH  MMM result A*B*R^-1 mod p, fully reduced
rsa_c  out  WIDTH  ciphertext, held until the next accepted start
eoc  out  1  level; high from completion until the next accepted start, a stop, or reset
busy  out  1  high in any state other than IDLE and DONE

Behaviour:
- Reset values (rst sampled high at a clk edge, regardless of ena): state IDLE; all outputs 0; internal registers (p_q, e_q, m_bar, x_bar, bit_idx) cleared to 0.
- ena low: no state, register or output changes. Pulses asserted during ena low are lost (the caller qualifies them with ena).
- Start acceptance:
  - Start is accepted only in IDLE or DONE.
  - On acceptance, latch p, e, m, const; clear eoc; set bit_idx = WIDTH-1.
  - Start while busy is ignored.
- Op issue rule:
  - Each op state spends one issue cycle asserting mmm_start with operands.
  - It then waits, operands held, for mmm_done.
  - On mmm_done it stores mmm_result and advances on the next edge.
- States and transitions:
  - IDLE: start -> PRE_M.
  - PRE_M: m_bar = MM(m, const) -> PRE_X.
  - PRE_X: x_bar = MM(1, const) (= R mod p) -> SQUARE.
  - SQUARE: x_bar = MM(x_bar, x_bar); if e_q[bit_idx] -> MULT, else -> NEXT.
  - MULT: x_bar = MM(x_bar, m_bar) -> NEXT.
  - NEXT (single cycle, no op): if bit_idx == 0 -> POST; else bit_idx -= 1 and -> SQUARE.
  - POST: rsa_c = MM(x_bar, 1) -> DONE.
  - DONE: eoc = 1; busy = 0; start -> PRE_M.
- Op count and latency:
  - Ops per run = 3 + WIDTH + popcount(e).
  - With MMM latency L (mmm_done L cycles after mmm_start), each op costs L+1 cycles.
  - Total from start-accept edge to eoc = ops*(L+1) + WIDTH (NEXT cycles) + 1.
- Leading zero bits of e are not skipped: squaring R mod p keeps R mod p. e = 0 yields rsa_c = 1.
- stop:
  - In any busy state: pulse mmm_abort if an op is in flight, go to IDLE, leave eoc = 0, hold rsa_c at its previous value.
  - In IDLE or DONE: clears eoc only.
  - start and stop in the same cycle: stop wins and start is ignored.
- mmm_done in a state that is not waiting for it (e.g. a stale done after stop): ignored.
- rst mid-operation: immediate IDLE with reset values. No mmm_abort is issued (the MMM shares rst).
- Latched operands are used for the whole run; changes on the rsa_* inputs mid-run have no effect.

Decomposition:
- Package rsa_pkg holds:
  - the state enum (IDLE, PRE_M, PRE_X, SQUARE, MULT, NEXT, POST, DONE);
  - an MMM operand-select encoding (SEL_M, SEL_ONE, SEL_CONST, SEL_XBAR, SEL_MBAR);
  - localparam ONE = 1 of width WIDTH.
- One sub-module is natural: rsa_op_issue, a per-op issue/wait handshake FSM (IDLE/ISSUE/WAIT, with abort) instantiated once. The top FSM only selects operands and the destination register.

Test Plan:
(All with WIDTH=8 and a behavioural MMM model with L=9.)
1. p=187, e=7, m=88, const=86, start -> 14 ops; rsa_c=11; eoc rises exactly 14*10+8+1 cycles after the start edge; busy low with eoc.
2. p=13, e=1, m=5, const=3 -> rsa_c=5. Then e=0, start again -> eoc drops on the start edge and re-rises with rsa_c=1.
3. Start scenario 1, assert stop during the SQUARE at bit_idx=4 -> mmm_abort is a single pulse; state IDLE; eoc=0; rsa_c unchanged; a late mmm_done is ignored.
4. Start scenario 1, pulse start again mid-run and change rsa_m to 3 -> result is still 11 and the op count is still 14.
5. Hold ena low for 20 cycles mid-run -> no output or mmm_start activity; completion is delayed by exactly 20 cycles with rsa_c=11. Start and stop in the same IDLE cycle -> stays IDLE.
6. Assert rst during MULT -> next cycle all outputs 0, state IDLE. A fresh start then gives the correct result (scenario 1 -> 11).
